// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB bus arbiter with parking on master 0, locked-transfer support
// and fixed-length burst protection.
module ahb_master_arbiter #(
    parameter int NO_OF_MASTERS = 4,
    parameter int HMASTER_WIDTH = $clog2(NO_OF_MASTERS)
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [NO_OF_MASTERS-1:0] hbusreq,
    input  logic [NO_OF_MASTERS-1:0] hlock,
    input  logic [1:0]               htrans,
    input  logic [2:0]               hburst,
    input  logic                     hready,
    output logic [NO_OF_MASTERS-1:0] hgrant,
    output logic [HMASTER_WIDTH-1:0] hmaster,
    output logic                     hmastlock
);

    typedef enum logic [1:0] {PARK, OWNED, LOCKED} state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    state_t                   state, state_next;
    logic [HMASTER_WIDTH-1:0] master_next, winner, cand;
    logic                     lock_tail, tail_next;
    logic [3:0]               beat_cnt, cnt_next, beat_idx, last_beat;
    logic                     any_req, fixed_burst, beat_valid, terminal, permit, do_arb;

    // Decide whether the beat being accepted closes the current burst.
    always_comb begin
        beat_valid  = (htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ);
        beat_idx    = (htrans == TRANS_NONSEQ) ? 4'd0 : beat_cnt + 4'd1;
        fixed_burst = 1'b0;
        last_beat   = 4'd0;
        case (hburst)
            BURST_SINGLE, BURST_INCR: last_beat = 4'd0;
            3'b010, 3'b011: begin fixed_burst = 1'b1; last_beat = 4'd3;  end
            3'b100, 3'b101: begin fixed_burst = 1'b1; last_beat = 4'd7;  end
            default:        begin fixed_burst = 1'b1; last_beat = 4'd15; end
        endcase
        terminal = beat_valid && ((hburst == BURST_INCR) || (beat_idx == last_beat));
        permit   = (state == PARK) || (htrans == TRANS_IDLE) || terminal ||
                   (!fixed_burst && !hbusreq[hmaster]);
    end

    // Search starts just past the owner and ends on the owner itself.
    always_comb begin
        winner  = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int k = 1; k <= NO_OF_MASTERS; k++) begin
            cand = HMASTER_WIDTH'((int'(hmaster) + k) % NO_OF_MASTERS);
            if (!any_req && hbusreq[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        cnt_next = beat_cnt;
        if (hready && htrans == TRANS_NONSEQ)
            cnt_next = 4'd0;
        else if (hready && htrans == TRANS_SEQ)
            cnt_next = beat_cnt + 4'd1;
    end

    // A locked owner keeps the bus while hlock is high, then for one more data phase.
    always_comb begin
        state_next  = state;
        master_next = hmaster;
        tail_next   = lock_tail;
        do_arb      = 1'b0;
        if (hready) begin
            case (state)
                LOCKED: begin
                    if (lock_tail) begin
                        tail_next = 1'b0;
                        if (permit)
                            do_arb = 1'b1;
                        else
                            state_next = OWNED;
                    end else if (!hlock[hmaster]) begin
                        tail_next = 1'b1;
                    end
                end
                default: do_arb = permit;
            endcase
        end
        if (do_arb) begin
            tail_next = 1'b0;
            if (!any_req) begin
                state_next  = PARK;
                master_next = '0;
            end else begin
                master_next = winner;
                state_next  = hlock[winner] ? LOCKED : OWNED;
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= PARK;
            hmaster   <= '0;
            lock_tail <= 1'b0;
            beat_cnt  <= 4'd0;
        end else begin
            state     <= state_next;
            hmaster   <= master_next;
            lock_tail <= tail_next;
            beat_cnt  <= cnt_next;
        end
    end

    assign hgrant    = {{(NO_OF_MASTERS-1){1'b0}}, 1'b1} << hmaster;
    assign hmastlock = (state == LOCKED);

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Scoreboard bench for ahb_master_arbiter: each driven cycle queues the expected
// owner/lock, which is popped and compared just after the clock edge.
module tb_ahb_master_arbiter;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [3:0] hbusreq, hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    typedef struct packed {
        logic [1:0] master;
        logic       lock;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ahb_master_arbiter #(.NO_OF_MASTERS(4)) dut (
        .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
        .htrans(htrans), .hburst(hburst), .hready(hready),
        .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic [3:0] req, input logic [3:0] lck,
                                  input logic [1:0] trans, input logic [2:0] burst, input logic rdy,
                                  input logic [1:0] exp_m, input logic exp_l);
        exp_t       e, got;
        logic [3:0] exp_g;
        @(negedge hclk);
        hbusreq = req;
        hlock   = lck;
        htrans  = trans;
        hburst  = burst;
        hready  = rdy;
        e.master = exp_m;
        e.lock   = exp_l;
        sb.push_back(e);
        @(posedge hclk);
        #1;
        got   = sb.pop_front();
        exp_g = 4'b0001 << got.master;
        check_output({tag, " hmaster"},   32'(hmaster),   32'(got.master));
        check_output({tag, " hmastlock"}, 32'(hmastlock), 32'(got.lock));
        check_output({tag, " hgrant"},    32'(hgrant),    32'(exp_g));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " hgrant"},    32'(hgrant),    32'h1);
        check_output({tag, " hmaster"},   32'(hmaster),   32'h0);
        check_output({tag, " hmastlock"}, 32'(hmastlock), 32'h0);
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        rr_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        hreset  = 1'b1;
        hbusreq = '0;
        hlock   = '0;
        htrans  = IDLE;
        hburst  = SINGLE;
        hready  = 1'b1;
        #12;
        check_reset_outputs("reset");
        hreset = 1'b0;

        for (int i = 0; i < 10; i++)
            apply_stimulus("park", 4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 2'd0, 1'b0);

        for (int i = 0; i < 5; i++)
            apply_stimulus("rr", 4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, rr_exp[i], 1'b0);

        apply_stimulus("own2",   4'b0100, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd2, 1'b0);
        apply_stimulus("b_nseq", 4'b0100, 4'b0000, NONSEQ, INCR4,  1'b1, 2'd2, 1'b0);
        apply_stimulus("b_seq1", 4'b1100, 4'b0000, SEQ,    INCR4,  1'b1, 2'd2, 1'b0);
        apply_stimulus("b_busy", 4'b1100, 4'b0000, BUSY,   INCR4,  1'b1, 2'd2, 1'b0);
        apply_stimulus("b_seq2", 4'b1100, 4'b0000, SEQ,    INCR4,  1'b1, 2'd2, 1'b0);
        apply_stimulus("b_seq3", 4'b1100, 4'b0000, SEQ,    INCR4,  1'b1, 2'd3, 1'b0);

        apply_stimulus("own2b",  4'b0100, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd2, 1'b0);
        apply_stimulus("w_nseq", 4'b0100, 4'b0000, NONSEQ, INCR4,  1'b1, 2'd2, 1'b0);
        apply_stimulus("w_seq1", 4'b1100, 4'b0000, SEQ,    INCR4,  1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++)
            apply_stimulus("w_stall", 4'b1000, 4'b0000, SEQ, INCR4, 1'b0, 2'd2, 1'b0);
        apply_stimulus("w_busy", 4'b1000, 4'b0000, BUSY,   INCR4,  1'b1, 2'd2, 1'b0);
        apply_stimulus("w_seq2", 4'b1000, 4'b0000, SEQ,    INCR4,  1'b1, 2'd2, 1'b0);
        apply_stimulus("w_seq3", 4'b1000, 4'b0000, SEQ,    INCR4,  1'b1, 2'd3, 1'b0);

        apply_stimulus("hold_busy", 4'b1001, 4'b0001, BUSY, INCR, 1'b1, 2'd3, 1'b0);
        apply_stimulus("drop",      4'b0001, 4'b0000, BUSY, INCR, 1'b1, 2'd0, 1'b0);
        apply_stimulus("incr_seq",  4'b0011, 4'b0000, SEQ,  INCR, 1'b1, 2'd1, 1'b0);
        apply_stimulus("to_park",   4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 2'd0, 1'b0);

        apply_stimulus("lk_win", 4'b1111, 4'b0010, NONSEQ, SINGLE, 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++)
            apply_stimulus("lk_hold", 4'b1111, 4'b0010, NONSEQ, SINGLE, 1'b1, 2'd1, 1'b1);
        apply_stimulus("lk_tail", 4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd1, 1'b1);
        apply_stimulus("lk_rel",  4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd2, 1'b0);

        apply_stimulus("rl_win", 4'b0010, 4'b0010, NONSEQ, SINGLE, 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 2; i++)
            apply_stimulus("rl_hold", 4'b0010, 4'b0010, NONSEQ, SINGLE, 1'b1, 2'd1, 1'b1);
        #1;
        hreset  = 1'b1;
        hbusreq = '0;
        hlock   = '0;
        htrans  = IDLE;
        #1;
        check_reset_outputs("async_rst");
        @(posedge hclk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge hclk);
        hreset = 1'b0;

        apply_stimulus("pr_stall", 4'b0100, 4'b0000, NONSEQ, SINGLE, 1'b0, 2'd0, 1'b0);
        apply_stimulus("pr_first", 4'b0100, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd2, 1'b0);

        check_output("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 Parameter NO_OF_MASTERS, default 4: number of requesting masters; legal range 2..16.
REQ-002 Parameter HMASTER_WIDTH, default $clog2(NO_OF_MASTERS): width of the master ID.
REQ-003 hclk  in  1  the only clock; all state changes on its rising edge.
REQ-004 hreset  in  1  asynchronous, active-high reset.
REQ-005 hbusreq  in  NO_OF_MASTERS  per-master bus request; bit i belongs to master i.
REQ-006 hlock  in  NO_OF_MASTERS  per-master locked-sequence request.
REQ-007 htrans  in  2  transfer type of the currently granted master: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 hburst  in  3  burst type of the currently granted master: SINGLE, INCR, WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16.
REQ-009 hready  in  1  combined transfer-complete; a beat is accepted when hready=1.
REQ-010 hgrant  out  NO_OF_MASTERS  one-hot grant.
REQ-011 hmaster  out  HMASTER_WIDTH  index of the granted master.
REQ-012 hmastlock  out  1  current ownership is a locked sequence.

Function
REQ-013 hgrant shall always be one-hot, and hmaster shall always equal the index of its set bit.
REQ-014 States: PARK, OWNED, LOCKED.
- PARK: no request is pending; master 0 is granted.
- OWNED: a requester holds the bus.
- LOCKED: the owner holds the bus under hlock.
REQ-015 Arbitration event: a rising edge with hready=1 and rearbitration permitted (REQ-016 to REQ-019). Grant, hmaster and state change only at arbitration events.
REQ-016 Rearbitration is permitted when any of the following holds:
- the state is PARK;
- the owner has dropped hbusreq;
- htrans=IDLE;
- the fixed-length burst beat counter has reached its terminal beat.
REQ-017 Beat counter (4 bits):
- loads 0 on an accepted NONSEQ;
- increments on an accepted SEQ;
- is unchanged on BUSY and IDLE.
REQ-018 Terminal beat, evaluated on the accepted beat:
- SINGLE: the NONSEQ itself;
- 4-beat bursts: count=3;
- 8-beat bursts: count=7;
- 16-beat bursts: count=15;
- INCR: every accepted beat is terminal, so undefined-length bursts may be split.
REQ-019 Rearbitration is never permitted mid fixed-length burst, including during BUSY beats.
REQ-020 Round-robin selection:
- search hbusreq starting from (hmaster+1) mod NO_OF_MASTERS, wrapping, and ending with hmaster itself;
- the first set bit wins;
- the winner may be the current owner.
REQ-021 If no hbusreq bit is set at an arbitration event, go to PARK: hgrant=0...01, hmaster=0, hmastlock=0.
REQ-022 If the winner has hlock set at the arbitration event, go to LOCKED and set hmastlock=1 on the same edge. Otherwise go to OWNED with hmastlock=0.
REQ-023 In LOCKED, rearbitration is suppressed while hlock[hmaster]=1, regardless of hbusreq, htrans and the burst counter.
REQ-024 After hlock[hmaster] falls, LOCKED shall remain until one further hready=1 edge (the final locked data phase). At that edge hmastlock=0 and REQ-016 arbitration applies.
REQ-025 hready=0 freezes all state, the beat counter and all outputs.
REQ-026 Simultaneous owner drop and new request: the owner dropping hbusreq at the same edge another master raises it grants the new master at that edge.
REQ-027 hlock from a non-owner is ignored until that master wins.
REQ-028 Changes to hbusreq or hlock when hready=0 take effect only at the next hready=1 edge.

Reset
REQ-029 While hreset=1, asynchronously:
- state=PARK;
- hgrant = 1 in bit 0 only;
- hmaster=0;
- hmastlock=0;
- beat counter=0;
- round-robin pointer=0.
REQ-030 Reset mid-burst or mid-lock shall abandon ownership immediately, with no completion of the current beat.
REQ-031 After hreset falls, the first arbitration occurs at the first hready=1 edge.

Verification
REQ-032 Idle park: after reset, hbusreq=0000 for 10 cycles, hready=1 -> hgrant=0001, hmaster=0, hmastlock=0 throughout.
REQ-033 Round robin:
- stimulus: hbusreq=1111, SINGLE NONSEQ every cycle, hready=1;
- response: hmaster sequence 1,2,3,0,1 on successive edges.
REQ-034 Burst hold:
- stimulus: master 2 owns; INCR4 with NONSEQ, SEQ, BUSY, SEQ, SEQ; master 3 requests from beat 1;
- response: hmaster stays 2 until the edge accepting the fourth SEQ-counted beat (count=3), then becomes 3.
REQ-035 Wait states:
- stimulus: same as REQ-034, plus hready=0 for 3 cycles mid-burst;
- response: hgrant, hmaster and counter unchanged during the stall; handover delayed by exactly 3 cycles.
REQ-036 Lock:
- stimulus: master 1 wins with hlock[1]=1 while hbusreq=1111; after 6 edges hlock[1] falls;
- response: hmastlock=1 and hmaster=1 for all locked edges plus one; then hmastlock=0 and hmaster=2.
REQ-037 Async reset mid-lock:
- stimulus: assert hreset between clock edges during REQ-036;
- response: hgrant=0001, hmaster=0, hmastlock=0 immediately, without waiting for hclk.
